// File: rtl/mac_pkg.sv
// mac_pkg: state encoding and the saturating/wrapping accumulate helper shared by mac_array and mac_lane
package mac_pkg;
  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;
  localparam int MAX_W = 64;
  // Operands live in the low w bits (w < MAX_W); returns {overflow, result}.
  // Bit positions are picked with masks so the width can stay a run-time argument.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] acc, input logic [MAX_W-1:0] prod,
                                             input int w, input logic signed_mode, input logic sat_en);
    logic [MAX_W:0] sum;
    logic [MAX_W-1:0] mask, smax, top, res;
    logic ov;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    smax = mask >> 1;
    top = smax ^ mask;
    sum = {1'b0, acc} + {1'b0, prod};
    ov = signed_mode ? !(|((acc ^ prod) & top)) && |((sum[MAX_W-1:0] ^ acc) & top) : |(sum >> w);
    res = !(ov && sat_en) ? sum[MAX_W-1:0] & mask : !signed_mode ? mask : |(acc & top) ? top : smax;
    return {ov, res};
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one MAC lane -- registered product, accumulator with sat/wrap, sticky overflow
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : synchronous clear, also drops an in-flight product
//   accept          : beat accepted this edge, a/b/sat_en are captured
//   clear_acc       : output handshake, clears accumulator and overflow
//   a, b, sat_en    : lane operand, broadcast operand, saturate select
//   acc, overflow   : accumulator value and sticky overflow flag
module mac_lane import mac_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  accept,
  input  logic                  clear_acc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sat_en,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  overflow
);
  localparam int PW = 2 * DATA_WIDTH;
  logic [PW-1:0] prod, prod_u;
  logic signed [PW-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0] prod_sx;
  logic [ACC_WIDTH-1:0] prod_x;
  logic pv, psat;
  logic [MAX_W:0] sum;
  logic unused_hi;
  assign prod_u = a * b;
  assign prod_s = $signed(a) * $signed(b);
  assign prod_sx = $signed(prod);
  assign prod_x = (SIGNED != 0) ? prod_sx : ACC_WIDTH'(prod);
  assign sum = sat_add(MAX_W'(acc), MAX_W'(prod_x), ACC_WIDTH, SIGNED != 0, psat);
  assign unused_hi = ^sum[MAX_W-1:ACC_WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      pv <= 1'b0;
      psat <= 1'b0;
      acc <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      pv <= 1'b0;
      acc <= '0;
      overflow <= 1'b0;
    end else begin
      pv <= accept;
      if (accept) begin
        prod <= (SIGNED != 0) ? prod_s : prod_u;
        psat <= sat_en;
      end
      if (clear_acc) begin
        acc <= '0;
        overflow <= 1'b0;
      end else if (pv) begin
        acc <= sum[ACC_WIDTH-1:0];
        overflow <= overflow | sum[MAX_W];
      end
    end
  end
endmodule

// File: rtl/mac_array.sv
// mac_array: NUM_LANES-lane multiply-accumulate engine producing one dot product per lane every VEC_LEN beats
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr                   : synchronous clear of all lane state; blocks acceptance that cycle
//   in_valid/in_ready     : beat handshake for a_in (per lane) and b_in (broadcast), sat_en per beat
//   out_valid/out_ready   : result handshake; acc_out holds while out_valid is high
//   acc_out, overflow     : per-lane accumulators and sticky overflow flags
//   busy                  : a vector is in progress or its result is undelivered
module mac_array import mac_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_LANES  = 8,
  parameter int VEC_LEN    = 8,
  parameter int SIGNED     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0]          b_in,
  input  logic                           sat_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*ACC_WIDTH-1:0] acc_out,
  output logic [NUM_LANES-1:0]           overflow,
  output logic                           busy
);
  localparam int CW = $clog2(VEC_LEN + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic accept, take;
  assign in_ready = (state == ACCUM) && !clr;
  assign accept = in_valid && in_ready;
  assign take = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr || take) begin
      state <= ACCUM;
      cnt <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= cnt + 1'b1;
        busy <= 1'b1;
        if (cnt == CW'(VEC_LEN - 1)) state <= FLUSH;
      end
      // The last product lands in the accumulators during FLUSH, so results are final on entering DONE.
      if (state == FLUSH) begin
        state <= DONE;
        out_valid <= 1'b1;
      end
    end
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mac_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SIGNED(SIGNED)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .accept(accept),
      .clear_acc(take),
      .a(a_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .b(b_in),
      .sat_en(sat_en),
      .acc(acc_out[i*ACC_WIDTH +: ACC_WIDTH]),
      .overflow(overflow[i])
    );
  end
endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: table-driven and randomized checks of mac_array across four parameter sets
module tb_mac_array;
  logic clk = 0, rst_n = 1, clr = 0, in_valid = 0, sat_en = 0, out_ready = 0;
  logic [63:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic rdy0, rdy1, rdy2, rdy3, ov0, ov1, ov2, ov3, bz0, bz1, bz2, bz3;
  logic [191:0] acc0, acc1;
  logic [127:0] acc2, acc3;
  logic [7:0] of0, of1, of2, of3;
  int checks = 0, failures = 0;
  logic [63:0] qa[$];
  logic [7:0] qb[$];
  logic qs[$];

  typedef struct packed {
    int s;
    logic [63:0] a;
    logic [7:0] b;
    logic sat;
    int gap;
    int hold;
    logic [191:0] ea;
    logic [7:0] eo;
  } vec_t;

  always #5 clk = ~clk;

  // sel 0: defaults (unsigned, 24b, VEC_LEN 8); sel 1: signed; sel 2: 16b unsigned VEC_LEN 2; sel 3: 16b signed VEC_LEN 4
  mac_array u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0), .a_in(a_in), .b_in(b_in),
    .sat_en(sat_en), .out_valid(ov0), .out_ready(out_ready), .acc_out(acc0), .overflow(of0), .busy(bz0));
  mac_array #(.SIGNED(1)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1), .a_in(a_in),
    .b_in(b_in), .sat_en(sat_en), .out_valid(ov1), .out_ready(out_ready), .acc_out(acc1), .overflow(of1), .busy(bz1));
  mac_array #(.ACC_WIDTH(16), .VEC_LEN(2)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
    .a_in(a_in), .b_in(b_in), .sat_en(sat_en), .out_valid(ov2), .out_ready(out_ready), .acc_out(acc2), .overflow(of2),
    .busy(bz2));
  mac_array #(.ACC_WIDTH(16), .VEC_LEN(4), .SIGNED(1)) u3 (.clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_ready(rdy3), .a_in(a_in), .b_in(b_in), .sat_en(sat_en), .out_valid(ov3), .out_ready(out_ready), .acc_out(acc3),
    .overflow(of3), .busy(bz3));

  function automatic int vlen(input int s);
    return s < 2 ? 8 : s == 2 ? 2 : 4;
  endfunction
  function automatic logic t_ready(input int s);
    return s == 0 ? rdy0 : s == 1 ? rdy1 : s == 2 ? rdy2 : rdy3;
  endfunction
  function automatic logic t_valid(input int s);
    return s == 0 ? ov0 : s == 1 ? ov1 : s == 2 ? ov2 : ov3;
  endfunction
  function automatic logic t_busy(input int s);
    return s == 0 ? bz0 : s == 1 ? bz1 : s == 2 ? bz2 : bz3;
  endfunction
  function automatic logic [7:0] t_ovf(input int s);
    return s == 0 ? of0 : s == 1 ? of1 : s == 2 ? of2 : of3;
  endfunction
  function automatic logic [23:0] lane(input int s, input int i);
    return s == 0 ? acc0[i*24 +: 24] : s == 1 ? acc1[i*24 +: 24] : s == 2 ? {8'h0, acc2[i*16 +: 16]} : {8'h0, acc3[i*16 +: 16]};
  endfunction
  function automatic logic [191:0] lanes(input int s);
    logic [191:0] r;
    for (int i = 0; i < 8; i++) r[i*24 +: 24] = lane(s, i);
    return r;
  endfunction

  task automatic chk(input string n, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic fill(input int s, input logic [63:0] a, input logic [7:0] b, input logic sat);
    qa.delete(); qb.delete(); qs.delete();
    repeat (vlen(s)) begin qa.push_back(a); qb.push_back(b); qs.push_back(sat); end
  endtask

  // Reference: per-lane dot product in plain integers, clamping or wrapping whenever the running sum leaves the range.
  task automatic model(input int s, output logic [191:0] ea, output logic [7:0] eo);
    int aw;
    bit sg;
    longint lim, hi, lo, acc, x, y;
    logic signed [7:0] as_v, bs_v;
    aw = s >= 2 ? 16 : 24;
    sg = (s == 1 || s == 3);
    lim = longint'(1) << aw;
    hi = sg ? lim / 2 - 1 : lim - 1;
    lo = sg ? -(lim / 2) : 0;
    ea = '0;
    eo = '0;
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      foreach (qa[k]) begin
        as_v = qa[k][i*8 +: 8];
        bs_v = qb[k];
        x = sg ? longint'(as_v) : longint'(qa[k][i*8 +: 8]);
        y = sg ? longint'(bs_v) : longint'(qb[k]);
        acc = acc + x * y;
        if (acc > hi) begin eo[i] = 1'b1; acc = qs[k] ? hi : acc - lim; end
        else if (acc < lo) begin eo[i] = 1'b1; acc = qs[k] ? lo : acc + lim; end
      end
      ea[i*24 +: 24] = 24'(acc & (lim - 1));
    end
  endtask

  task automatic sync_clr(input int s);
    @(negedge clk);
    clr = 1; in_valid = 1;
    #1 chk("clr_blocks_ready", t_ready(s), 0);
    @(negedge clk);
    clr = 0; in_valid = 0;
  endtask

  task automatic feed(input int s, input int gap_max);
    int w;
    foreach (qa[k]) begin
      in_valid = 0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      in_valid = 1; a_in = qa[k]; b_in = qb[k]; sat_en = qs[k];
      #1 w = 0;
      while (!t_ready(s) && w < 20) begin @(negedge clk); #1 w++; end
      chk("feed_ready", t_ready(s), 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic do_vec(input int s, input bit do_clr, input int gap_max, input int hold,
                        input logic [191:0] ea, input logic [7:0] eo, input string tag);
    logic [191:0] snap;
    if (do_clr) sync_clr(s);
    feed(s, gap_max);
    chk({tag, ".busy"}, t_busy(s), 1);
    chk({tag, ".valid_early"}, t_valid(s), 0);
    @(negedge clk);
    chk({tag, ".valid_lat"}, t_valid(s), 1);
    snap = lanes(s);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, t_valid(s), 1);
      chk({tag, ".hold_ready"}, t_ready(s), 0);
      chk({tag, ".hold_acc"}, lanes(s), snap);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("%s.acc%0d", tag, i), lane(s, i), ea[i*24 +: 24]);
    chk({tag, ".ovf"}, t_ovf(s), eo);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    #1;
    chk({tag, ".post_valid"}, t_valid(s), 0);
    chk({tag, ".post_ready"}, t_ready(s), 1);
    chk({tag, ".post_busy"}, t_busy(s), 0);
    chk({tag, ".post_ovf"}, t_ovf(s), 0);
    chk({tag, ".post_acc"}, lanes(s), 0);
  endtask

  function automatic vec_t mk(input int s, input logic [63:0] a, input logic [7:0] b, input logic sat, input int gap,
                              input int hold, input logic [191:0] ea, input logic [7:0] eo);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.sat = sat; v.gap = gap; v.hold = hold; v.ea = ea; v.eo = eo;
    return v;
  endfunction

  initial begin
    vec_t tbl[9];
    logic [191:0] base, ea;
    logic [7:0] eo;
    int s;
    base = {24'h80, 24'h70, 24'h60, 24'h50, 24'h40, 24'h30, 24'h20, 24'h10};
    tbl[0] = mk(0, 64'h0807060504030201, 8'd2, 0, 0, 5, base, 8'h00);
    tbl[1] = mk(0, 64'h0807060504030201, 8'd2, 0, 2, 0, base, 8'h00);
    tbl[2] = mk(1, {8{8'hFD}}, 8'd5, 0, 0, 1, {8{24'hFFFF88}}, 8'h00);
    tbl[3] = mk(2, {8{8'hFF}}, 8'hFF, 1, 0, 0, {8{24'h00FFFF}}, 8'hFF);
    tbl[4] = mk(2, {8{8'hFF}}, 8'hFF, 0, 1, 0, {8{24'h00FC02}}, 8'hFF);
    tbl[5] = mk(0, {8{8'hFF}}, 8'hFF, 0, 0, 0, {8{24'h07F008}}, 8'h00);
    tbl[6] = mk(3, {8{8'h80}}, 8'h80, 1, 0, 0, {8{24'h007FFF}}, 8'hFF);
    tbl[7] = mk(3, {8{8'h80}}, 8'h7F, 1, 0, 0, {8{24'h008000}}, 8'hFF);
    tbl[8] = mk(3, {8{8'h80}}, 8'h80, 0, 0, 0, {8{24'h000000}}, 8'hFF);

    #1 rst_n = 0;
    #1;
    chk("rst_acc0", lanes(0), 0);
    chk("rst_acc3", lanes(3), 0);
    chk("rst_valid", {ov0, ov1, ov2, ov3}, 0);
    chk("rst_busy", {bz0, bz1, bz2, bz3}, 0);
    chk("rst_ovf", {of0, of1, of2, of3}, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_ready", {rdy0, rdy1, rdy2, rdy3}, 4'hF);

    for (int n = 0; n < 9; n++) begin
      fill(tbl[n].s, tbl[n].a, tbl[n].b, tbl[n].sat);
      do_vec(tbl[n].s, 1, tbl[n].gap, tbl[n].hold, tbl[n].ea, tbl[n].eo, $sformatf("tbl%0d", n));
    end

    // clr with the 4th product still in the multiply register
    sync_clr(0);
    fill(0, 64'h0807060504030201, 8'd2, 0);
    qa = qa[0:3]; qb = qb[0:3]; qs = qs[0:3];
    feed(0, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    #1;
    chk("clr_acc", lanes(0), 0);
    chk("clr_busy", bz0, 0);
    @(negedge clk);
    chk("clr_discard", lanes(0), 0);
    chk("clr_ready", rdy0, 1);
    fill(0, 64'h0807060504030201, 8'd2, 0);
    do_vec(0, 0, 0, 0, base, 8'h00, "after_clr");

    // asynchronous reset between edges, mid-vector
    sync_clr(0);
    fill(0, 64'h0807060504030201, 8'd2, 0);
    qa = qa[0:2]; qb = qb[0:2]; qs = qs[0:2];
    feed(0, 0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_acc", lanes(0), 0);
    chk("mid_rst_busy", bz0, 0);
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_ovf", of0, 0);
    @(negedge clk);
    rst_n = 1;
    fill(0, 64'h0807060504030201, 8'd2, 0);
    do_vec(0, 0, 0, 0, base, 8'h00, "after_rst");

    for (int n = 0; n < 16; n++) begin
      s = n % 4;
      qa.delete(); qb.delete(); qs.delete();
      repeat (vlen(s)) begin
        qa.push_back({$urandom, $urandom});
        qb.push_back(8'($urandom));
        qs.push_back(1'($urandom));
      end
      model(s, ea, eo);
      do_vec(s, 1, $urandom_range(1, 0), $urandom_range(2, 0), ea, eo, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
